// File: rtl/gate_seq_ctrl.sv
// Vector-sweep sequencer for the shared 3-input gate network (D = (A&B) | ~C, E = ~C).
// Applies each vector, holds it for SETTLE_CYC+2 cycles, samples D/E and tallies mismatches.
module gate_seq_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int NUM_VEC    = 8,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             D_in,
    input  logic             E_in,
    output logic             A_out,
    output logic             B_out,
    output logic             C_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    state_t           state;
    logic [2:0]       idx;
    logic [3:0]       settle_cnt;
    logic             exp_d, exp_e, mismatch;
    logic [ERR_W-1:0] err_nxt;
    logic [2:0]       idx_inc;

    // Expected response is derived from the index, not from the driven pins.
    always_comb begin
        exp_d    = (idx[2] & idx[1]) | ~idx[0];
        exp_e    = ~idx[0];
        mismatch = (D_in != exp_d) || (E_in != exp_e);
        err_nxt  = err_cnt;
        if (mismatch && (err_cnt != {ERR_W{1'b1}}))
            err_nxt = err_cnt + 1'b1;
        idx_inc  = idx + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            {A_out, B_out, C_out} <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                state      <= IDLE;
                idx        <= '0;
                settle_cnt <= '0;
                {A_out, B_out, C_out} <= 3'b000;
                busy       <= 1'b0;
                pass       <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= APPLY;
                            idx        <= '0;
                            {A_out, B_out, C_out} <= 3'b000;
                            busy       <= 1'b1;
                            pass       <= 1'b0;
                            err_cnt    <= '0;
                            fail_vec   <= '0;
                            fail_valid <= 1'b0;
                        end
                    end
                    APPLY: begin
                        settle_cnt <= SETTLE_LD;
                        state      <= (SETTLE_CYC == 0) ? CHECK : SETTLE;
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt - 4'd1;
                        if (settle_cnt == 4'd1)
                            state <= CHECK;
                    end
                    CHECK: begin
                        err_cnt <= err_nxt;
                        if (mismatch && !fail_valid) begin
                            fail_vec   <= idx;
                            fail_valid <= 1'b1;
                        end
                        if (idx == LAST_VEC) begin
                            state <= DONE;
                            idx   <= '0;
                            {A_out, B_out, C_out} <= 3'b000;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt == '0);
                        end else begin
                            state <= APPLY;
                            idx   <= idx_inc;
                            {A_out, B_out, C_out} <= idx_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: three instances (default, ERR_W=3, SETTLE_CYC=0) against a
// sweep-time model plus directed latency/result checks and randomized stimulus.
module tb_gate_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start [3];
    logic       abort [3];
    int         mode  [3];   // 0 clean, 1 D stuck-at-0, 2 E inverted, 3 random noise
    logic [1:0] noise [3];
    logic       a [3], b [3], c [3], d [3], e [3];
    logic       busy [3], done [3], pass [3], fvalid [3];
    logic [2:0] fvec [3];
    logic [3:0] err0, err2, errv [3];
    logic [2:0] err1;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    localparam int S_P  [3] = '{2, 2, 0};
    localparam int EW_P [3] = '{4, 3, 4};
    localparam int NV = 8;

    gate_seq_ctrl u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .D_in(d[0]), .E_in(e[0]), .A_out(a[0]), .B_out(b[0]), .C_out(c[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err0),
        .fail_vec(fvec[0]), .fail_valid(fvalid[0]));

    gate_seq_ctrl #(.ERR_W(3)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .D_in(d[1]), .E_in(e[1]), .A_out(a[1]), .B_out(b[1]), .C_out(c[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err1),
        .fail_vec(fvec[1]), .fail_valid(fvalid[1]));

    gate_seq_ctrl #(.SETTLE_CYC(0)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .D_in(d[2]), .E_in(e[2]), .A_out(a[2]), .B_out(b[2]), .C_out(c[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err2),
        .fail_vec(fvec[2]), .fail_valid(fvalid[2]));

    assign errv[0] = err0;
    assign errv[1] = {1'b0, err1};
    assign errv[2] = err2;

    // Gate network with optional fault injection.
    for (genvar i = 0; i < 3; i++) begin : g_net
        assign d[i] = (mode[i] == 1) ? 1'b0
                    : (((a[i] & b[i]) | ~c[i]) ^ ((mode[i] == 3) & noise[i][0]));
        assign e[i] = (~c[i]) ^ (mode[i] == 2) ^ ((mode[i] == 3) & noise[i][1]);
    end

    // Model: a sweep is just "cycles elapsed since start"; vector = t / hold.
    typedef struct {
        bit act;
        int t;
        int err;
        int fv;
        bit fval;
        bit pass;
        bit done;
    } m_t;

    m_t m [3];

    function automatic m_t step(m_t s, int S, int EW, bit r, bit ab, bit st, bit dd, bit ee);
        m_t n;
        int hold, v, ea, eb, ec;
        bit ed, ex;
        n = s;
        n.done = 0;
        hold = S + 2;
        if (!r) begin
            n = '{default: 0};
        end else if (s.act) begin
            if (ab) begin
                n.act = 0;
                n.pass = 0;
            end else begin
                v = s.t / hold;
                if (s.t % hold == hold - 1) begin
                    ea = v / 4; eb = (v / 2) % 2; ec = v % 2;
                    ed = ((ea & eb) != 0) || (ec == 0);
                    ex = (ec == 0);
                    if (dd != ed || ee != ex) begin
                        if (n.err < (1 << EW) - 1) n.err++;
                        if (!n.fval) begin n.fval = 1; n.fv = v; end
                    end
                end
                n.t = s.t + 1;
                if (n.t == NV * hold) begin
                    n.act = 0;
                    n.done = 1;
                    n.pass = (n.err == 0);
                end
            end
        end else if (st) begin
            n.act = 1; n.t = 0; n.err = 0; n.fv = 0; n.fval = 0; n.pass = 0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle compare, then advance the model across the coming edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [13:0] got, exp;
            logic [2:0]  ev;
            ev  = m[i].act ? 3'(m[i].t / (S_P[i] + 2)) : 3'd0;
            got = {a[i], b[i], c[i], busy[i], done[i], pass[i], errv[i], fvec[i], fvalid[i]};
            exp = {ev, m[i].act, m[i].done, m[i].pass, 4'(m[i].err), 3'(m[i].fv), m[i].fval};
            if (chk_en) chk($sformatf("cycle_u%0d", i), 32'(got), 32'(exp));
        end
        for (int i = 0; i < 3; i++)
            m[i] = step(m[i], S_P[i], EW_P[i], rst_n, abort[i], start[i], d[i], e[i]);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // One-cycle start pulse; returns cycles from the start cycle to the done cycle.
    task automatic run_sweep(input int i, output int lat);
        tick(1);
        start[i] = 1;
        tick(1);
        start[i] = 0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (done[i] === 1'b1) break;
            lat++;
            if (lat > 200) begin
                nchk++; nerr++;
                $display("FAIL done_timeout_u%0d: no done within 200 cycles", i);
                break;
            end
        end
    endtask

    initial begin
        int lat, cyc;
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; abort[i] = 0; mode[i] = 0; noise[i] = 0;
            m[i] = '{default: 0};
        end
        tick(3);
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        chk("reset_busy", 32'(busy[0]), 0);
        chk("reset_err", 32'(err0), 0);

        run_sweep(0, lat);
        chk("clean_latency", lat, 33);
        chk("clean_pass", 32'(pass[0]), 1);
        chk("clean_err", 32'(err0), 0);
        chk("clean_fvalid", 32'(fvalid[0]), 0);

        run_sweep(2, lat);
        chk("settle0_latency", lat, 17);
        chk("settle0_pass", 32'(pass[2]), 1);

        mode[0] = 1;
        run_sweep(0, lat);
        chk("stuckd_err", 32'(err0), 5);
        chk("stuckd_fvec", 32'(fvec[0]), 0);
        chk("stuckd_fvalid", 32'(fvalid[0]), 1);
        chk("stuckd_pass", 32'(pass[0]), 0);

        mode[1] = 2;
        run_sweep(1, lat);
        chk("inve_err_sat", 32'(err1), 7);
        chk("inve_fvec", 32'(fvec[1]), 0);
        chk("inve_pass", 32'(pass[1]), 0);
        mode[1] = 0;

        // Abort during vector 3 with errors already logged on vectors 0 and 2.
        tick(1);
        start[0] = 1;
        tick(1);
        start[0] = 0;
        cyc = 0;
        while (!({a[0], b[0], c[0]} == 3'd3 && busy[0]) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("abort_reach_v3", 32'(cyc < 100), 1);
        tick(1);
        abort[0] = 1;
        start[0] = 1;
        tick(1);
        abort[0] = 0;
        start[0] = 0;
        @(negedge clk);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_abc", 32'({a[0], b[0], c[0]}), 0);
        chk("abort_err_held", 32'(err0), 2);
        mode[0] = 0;
        run_sweep(0, lat);
        chk("post_abort_latency", lat, 33);
        chk("post_abort_err", 32'(err0), 0);

        // start held high: back-to-back sweeps, second starts on the DONE cycle.
        tick(1);
        start[0] = 1;
        tick(40);
        start[0] = 0;
        tick(40);

        // Reset mid-sweep.
        start[0] = 1; start[1] = 1;
        tick(1);
        start[0] = 0; start[1] = 0;
        tick(10);
        rst_n = 0;
        tick(2);
        rst_n = 1;
        @(negedge clk);
        chk("midreset_busy", 32'(busy[0]), 0);
        chk("midreset_abc", 32'({a[0], b[0], c[0]}), 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            tick(1);
            rst_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 19) == 0);
                abort[i] = ($urandom_range(0, 59) == 0);
                noise[i] = 2'($urandom);
                if ($urandom_range(0, 49) == 0) mode[i] = $urandom_range(0, 3);
            end
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin start[i] = 0; abort[i] = 0; end
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
